gate_function_prober: RTL and testbench
=======================================

// Module: gate_function_prober
// PURPOSE
// Active probe that determines which function a 2-input programmable gate is
// configured for, by driving its a/b inputs and reading back y. It is the
// identification end of the gate's f1/f0 select, and it recovers the code
// from the gate's behaviour: 00=AND, 01=OR, 10=NAND, 11=NOR.
// Used in self-test: applies all four input vectors, records a truth table,
// then decodes it to a function code or flags a mismatch.
// PARAMETERS
// SETTLE_CYCLES  2  extra clocks each vector is held before y is sampled (>=0)
// PORTS
// clk          in   1  clock, rising edge
// rst_n        in   1  asynchronous active-low reset
// start        in   1  request a probe run; accepted only in IDLE
// abort        in   1  synchronous abort; returns to IDLE, no result
// gate_y       in   1  y output of the gate under probe
// probe_a      out  1  drives gate input a
// probe_b      out  1  drives gate input b
// busy         out  1  high while a run is in progress
// done         out  1  one-cycle pulse when a run completes
// truth_table  out  4  bit {a,b} = sampled y for that vector
// func_code    out  2  decoded f1f0 code; 00 when func_err=1
// func_valid   out  1  truth_table matches one of the 4 functions
// func_err     out  1  truth_table matches none of the 4 functions
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE. All outputs 0, and the vector counter
//   and hold counter are cleared.
// - States: IDLE -> PROBE (vec 0..3) -> IDLE. The done pulse is issued on the
//   transition back to IDLE.
// - IDLE: probe_a=probe_b=0 and busy=0. When start=1 at an edge, the run is
//   accepted: go to PROBE, vec=0, hold=0, and clear func_valid, func_err and
//   truth_table.
// - PROBE: {probe_a,probe_b}=vec, applied in the order 00,01,10,11. busy=1.
//   - Each vector is held for SETTLE_CYCLES+1 clocks.
//   - At the edge where hold==SETTLE_CYCLES, gate_y is stored into
//     truth_table[vec], then vec increments and hold clears.
// - Completion: at the edge that samples vec=3, the block returns to IDLE.
//   - Decode uses the stored bits plus the live gate_y.
//   - truth_table, func_code, func_valid and func_err all update on that same
//     edge, and done=1 for the following cycle.
//   - Results hold until the next accepted start or reset.
// - Decode (truth_table[3:0]): 4'b1000->00, 4'b1110->01, 4'b0111->10,
//   4'b0001->11. Any other value gives func_err=1, func_valid=0, func_code=00.
//   func_valid and func_err are never both 1.
// - Latency: start accepted at edge E gives done high in the cycle after edge
//   E+4*(SETTLE_CYCLES+1). With the default that is E+12.
// - start while busy: ignored. start in the done cycle: accepted, because the
//   block is already in IDLE.
// - abort in PROBE: next edge goes to IDLE with probe outputs 0. There is no
//   done pulse and func_valid/func_err stay 0. abort has priority over a
//   sample on the same edge. abort in IDLE has no effect.
// - Reset mid-run: everything returns to reset values immediately.
// - SETTLE_CYCLES=0: one clock per vector. Counter width is
//   max(1,$clog2(SETTLE_CYCLES+1)).
// TESTING
// 1. Gate model set to f=00 (AND), start pulse -> done at E+12,
//    truth_table=1000, func_code=00, func_valid=1.
// 2. Repeat with f=01/10/11 -> truth_table=1110/0111/0001 and
//    func_code=01/10/11, func_valid=1 each.
// 3. gate_y tied 1 -> truth_table=1111, func_err=1, func_valid=0,
//    func_code=00.
// 4. Check the probe_a/b sequence 00,01,10,11, each held 3 clocks. start
//    pulsed mid-run -> ignored, done still at E+12.
// 5. abort at E+5 -> IDLE at E+6, no done, busy=0, func_valid=0. rst_n low
//    mid-run -> outputs 0 asynchronously.
// 6. SETTLE_CYCLES=0 build, OR gate -> done at E+4, code 01. start in the
//    done cycle -> second run accepted.

Source files
------------

// File: rtl/gate_function_prober_if.sv
// Probe bus for gate_function_prober: run control, gate drive/readback and decoded result.
// Latency: n/a (signal bundle only).
// Backpressure: none; start is a request sampled only while the prober is idle.
//
// Signals:
//   start, abort        run request / synchronous cancel (controller -> prober)
//   gate_y              y output of the gate under probe (gate -> prober)
//   probe_a, probe_b    drive the gate's a/b inputs (prober -> gate)
//   busy, done          run in progress / one-cycle completion pulse
//   truth_table         bit {a,b} holds the sampled y for that vector
//   func_code           decoded f1f0 (00 AND, 01 OR, 10 NAND, 11 NOR)
//   func_valid/func_err table matched one of the four functions / matched none
interface gate_function_prober_if;
   logic       start;
   logic       abort;
   logic       gate_y;
   logic       probe_a;
   logic       probe_b;
   logic       busy;
   logic       done;
   logic [3:0] truth_table;
   logic [1:0] func_code;
   logic       func_valid;
   logic       func_err;

   // master: the side requesting runs and modelling the gate
   modport master (
      output start, abort, gate_y,
      input  probe_a, probe_b, busy, done, truth_table, func_code, func_valid, func_err
   );

   // slave: the prober itself
   modport slave (
      input  start, abort, gate_y,
      output probe_a, probe_b, busy, done, truth_table, func_code, func_valid, func_err
   );
endinterface

// File: rtl/gate_function_prober.sv
// Identifies a 2-input programmable gate's function by walking {a,b} through 00,01,10,11 and decoding y.
// Latency: start accepted at edge E -> done high in the cycle after edge E + 4*(SETTLE_CYCLES+1).
// Backpressure: start ignored while busy; abort cancels a run on the next edge with no result.
//
// Ports: clk, rst_n (async active-low) plus the slave modport of gate_function_prober_if.
module gate_function_prober #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gate_function_prober_if.slave pif
);

   localparam int HW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE_CYCLES);

   typedef enum logic {
      IDLE  = 1'b0,
      PROBE = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      vec;
   logic [HW-1:0]   hold;
   logic [3:0]      truth_table;
   logic [1:0]      func_code;
   logic            func_valid;
   logic            func_err;
   logic            done;
   logic            accept;
   logic            sample;
   logic            last;
   logic [3:0]      tt_final;
   logic [2:0]      dec;

   // {valid, code} for a completed truth table
   function automatic logic [2:0] decode(input logic [3:0] tt);
      case (tt)
         4'b1000: decode = 3'b1_00;  // AND
         4'b1110: decode = 3'b1_01;  // OR
         4'b0111: decode = 3'b1_10;  // NAND
         4'b0001: decode = 3'b1_11;  // NOR
         default: decode = 3'b0_00;
      endcase
   endfunction

   // The final vector's bit is not yet stored when the decode happens, so it
   // is taken straight from the gate.
   assign tt_final = {pif.gate_y, truth_table[2:0]};
   assign dec      = decode(tt_final);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      sample    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (pif.start) begin
               accept    = 1'b1;
               state_nxt = PROBE;
            end
         end
         PROBE: begin
            // abort wins over a sample landing on the same edge
            if (pif.abort) begin
               state_nxt = IDLE;
            end else if (hold == HOLD_LAST) begin
               sample = 1'b1;
               if (vec == 2'd3) begin
                  last      = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec         <= '0;
         hold        <= '0;
         truth_table <= '0;
         func_code   <= '0;
         func_valid  <= 1'b0;
         func_err    <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            vec         <= '0;
            hold        <= '0;
            truth_table <= '0;
            func_code   <= '0;
            func_valid  <= 1'b0;
            func_err    <= 1'b0;
         end else if (state == PROBE) begin
            if (pif.abort) begin
               vec  <= '0;
               hold <= '0;
            end else if (sample) begin
               truth_table[vec] <= pif.gate_y;
               vec              <= vec + 2'd1;  // wraps to 0 after the last vector
               hold             <= '0;
               if (last) begin
                  func_valid <= dec[2];
                  func_err   <= ~dec[2];
                  func_code  <= dec[1:0];
               end
            end else begin
               hold <= hold + 1'b1;
            end
         end
      end
   end

   assign pif.busy        = (state == PROBE);
   assign pif.probe_a     = (state == PROBE) & vec[1];
   assign pif.probe_b     = (state == PROBE) & vec[0];
   assign pif.done        = done;
   assign pif.truth_table = truth_table;
   assign pif.func_code   = func_code;
   assign pif.func_valid  = func_valid;
   assign pif.func_err    = func_err;

endmodule

// File: tb/tb_gate_function_prober.sv
// Bench for gate_function_prober: a settle-2 and a settle-0 instance probing table-driven gate models.
// Latency: checks done exactly at E+12 (settle 2) and E+4 (settle 0).
// Backpressure: exercises start while busy, start in the done cycle, abort and mid-run reset.
module tb_gate_function_prober;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [3:0] tbl2;
   logic [3:0] tbl0;

   gate_function_prober_if if2 ();
   gate_function_prober_if if0 ();

   // gate models: y looked up from a truth table indexed by {a,b}
   assign if2.gate_y = tbl2[{if2.probe_a, if2.probe_b}];
   assign if0.gate_y = tbl0[{if0.probe_a, if0.probe_b}];

   gate_function_prober #(.SETTLE_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .pif(if2));
   gate_function_prober #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .pif(if0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Truth table of a gate function, evaluated from its logic definition
   function automatic logic [3:0] fn_table(input int code);
      logic [3:0] t;
      logic a, b;
      t = '0;
      for (int v = 0; v < 4; v++) begin
         a = v[1];
         b = v[0];
         case (code)
            0: t[v] = a & b;
            1: t[v] = a | b;
            2: t[v] = ~(a & b);
            default: t[v] = ~(a | b);
         endcase
      end
      return t;
   endfunction

   // Expected {valid, err, code}: search the four functions for one whose table matches
   function automatic logic [3:0] expect_result(input logic [3:0] tt);
      logic [3:0] r;
      r = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         if (fn_table(c) == tt) r = {2'b10, 2'(c)};
      end
      return r;
   endfunction

   task automatic chk_result2(input string tag, input logic [3:0] tt);
      chk({tag, "_tt"}, {28'd0, if2.truth_table}, {28'd0, tt});
      chk({tag, "_res"}, {28'd0, if2.func_valid, if2.func_err, if2.func_code},
          {28'd0, expect_result(tt)});
   endtask

   // One full run on the settle-2 instance; start re-pulsed at step mid (must be ignored)
   task automatic run2(input logic [3:0] tbl, input int mid);
      int per;
      per = 3;
      tbl2 = tbl;
      @(posedge clk); #1 if2.start = 1'b1;
      @(posedge clk); #1 if2.start = 1'b0;   // edge E accepted the run
      for (int k = 0; k <= 4 * per; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if2.start = (k == mid);
         if (k < 4 * per)
            chk("seq", {28'd0, if2.busy, if2.done, if2.probe_a, if2.probe_b},
                {28'd0, 2'b10, 2'(k / per)});
         else
            chk("done", {28'd0, if2.busy, if2.done, if2.probe_a, if2.probe_b}, 32'h4);
      end
      if2.start = 1'b0;
      chk_result2("run", tbl);
      @(posedge clk); #1;
      chk("after_done", {30'd0, if2.busy, if2.done}, 32'h0);
      chk_result2("hold", tbl);
   endtask

   initial begin
      logic [3:0] t;
      int mode;
      checks = 0;
      errors = 0;
      tbl2 = 4'h0;
      tbl0 = 4'h0;
      if2.start = 1'b0; if2.abort = 1'b0;
      if0.start = 1'b0; if0.abort = 1'b0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #8;
      chk("rst_out", {26'd0, if2.busy, if2.done, if2.probe_a, if2.probe_b, if2.func_valid, if2.func_err}, 32'h0);
      chk("rst_res", {26'd0, if2.truth_table, if2.func_code}, 32'h0);
      chk("rst_out0", {26'd0, if0.busy, if0.done, if0.truth_table}, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // the four functions, then y tied high
      for (int c = 0; c < 4; c++) run2(fn_table(c), $urandom_range(1, 10));
      run2(4'hF, 5);

      // randomized gates: legal functions, stuck outputs or arbitrary tables
      for (int i = 0; i < 12; i++) begin
         mode = $urandom_range(0, 5);
         if (mode < 4) t = fn_table(mode);
         else if (mode == 4) t = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
         else t = 4'($urandom_range(0, 15));
         run2(t, $urandom_range(1, 10));
      end

      // abort in IDLE does nothing to held results
      t = if2.truth_table;
      if2.abort = 1'b1;
      @(posedge clk); #1 if2.abort = 1'b0;
      chk("idle_abort", {30'd0, if2.busy, if2.done}, 32'h0);
      chk_result2("idle_abort", t);

      // abort asserted after E+5, taken at E+6 (also a sample edge)
      tbl2 = fn_table(1);
      @(posedge clk); #1 if2.start = 1'b1;
      @(posedge clk); #1 if2.start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
      end
      chk("pre_abort", {30'd0, if2.busy, if2.probe_b}, 32'h3);
      if2.abort = 1'b1;
      @(posedge clk); #1 if2.abort = 1'b0;
      chk("abort_idle", {28'd0, if2.busy, if2.done, if2.probe_a, if2.probe_b}, 32'h0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("abort_nodone", {29'd0, if2.done, if2.func_valid, if2.func_err}, 32'h0);
      end

      // asynchronous reset mid-run
      tbl2 = 4'hF;
      @(posedge clk); #1 if2.start = 1'b1;
      @(posedge clk); #1 if2.start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", {28'd0, if2.busy, if2.done, if2.probe_a, if2.probe_b}, 32'h0);
      chk("mid_rst_res", {24'd0, if2.truth_table, if2.func_code, if2.func_valid, if2.func_err}, 32'h0);
      #2 rst_n = 1'b1;

      // settle-0 instance: OR, then a NOR run started in the done cycle
      tbl0 = fn_table(1);
      @(posedge clk); #1 if0.start = 1'b1;
      @(posedge clk); #1 if0.start = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
               @(posedge clk); #1;
            end
            if (k < 4)
               chk("seq0", {28'd0, if0.busy, if0.done, if0.probe_a, if0.probe_b}, {28'd0, 2'b10, 2'(k)});
            else
               chk("done0", {28'd0, if0.busy, if0.done, if0.probe_a, if0.probe_b}, 32'h4);
         end
         chk("tt0", {28'd0, if0.truth_table}, {28'd0, (r == 0) ? fn_table(1) : fn_table(3)});
         chk("res0", {28'd0, if0.func_valid, if0.func_err, if0.func_code},
             {28'd0, expect_result((r == 0) ? fn_table(1) : fn_table(3))});
         if (r == 0) begin
            tbl0 = fn_table(3);
            if0.start = 1'b1;
            @(posedge clk); #1 if0.start = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
